// File: rtl/sad_pkg.sv
// ---------------------------------------------------------------------------
// sad_pkg
//   Shared definitions for the sum-of-absolute-differences controller.
//   - sad_state_t : controller state encoding
//   - SAD_N       : elements per pass (256)
//   - SAD_MAX_LAT : largest supported A/B memory read latency (3)
//   - sad_lat_last: last drain-counter value for a given memory latency
// ---------------------------------------------------------------------------
package sad_pkg;

    localparam int SAD_N       = 256;
    localparam int SAD_MAX_LAT = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ACC   = 3'd2,
        S_DRAIN = 3'd3,
        S_STORE = 3'd4,
        S_DONE  = 3'd5
    } sad_state_t;

    // DRAIN lasts `lat` cycles; the counter runs 0..lat-1. With no latency
    // DRAIN is skipped, so the value is irrelevant and pinned to 0.
    function automatic logic [1:0] sad_lat_last(input int lat);
        int last;
        last = (lat > 0) ? lat - 1 : 0;
        return last[1:0];
    endfunction

endpackage

// File: rtl/sad_lat_pipe.sv
// ---------------------------------------------------------------------------
// sad_lat_pipe
//   Valid-token delay line that lines up the accumulate strobe with data
//   returning from the A/B memories. DEPTH = 0 degenerates to a wire.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset, empties the pipe
//   flush_i  in   synchronous flush, empties the pipe on the next edge
//   valid_i  in   token issued this cycle
//   valid_o  out  token issued DEPTH cycles ago
// ---------------------------------------------------------------------------
module sad_lat_pipe #(
    parameter int DEPTH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o
);

    if (DEPTH == 0) begin : g_wire
        assign valid_o = valid_i;

        // Clock, reset and flush have nothing to act on in this build.
        logic unused_w;
        assign unused_w = clk ^ rst ^ flush_i;
    end else begin : g_shift
        logic stage_q [DEPTH];

        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_q[0] <= 1'b0;
                    end else if (flush_i) begin
                        stage_q[0] <= 1'b0;
                    end else begin
                        stage_q[0] <= valid_i;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        stage_q[gi] <= 1'b0;
                    end else if (flush_i) begin
                        stage_q[gi] <= 1'b0;
                    end else begin
                        stage_q[gi] <= stage_q[gi-1];
                    end
                end
            end
        end

        assign valid_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/sad_ctrl.sv
// ---------------------------------------------------------------------------
// sad_ctrl
//   Control FSM for one 256-element sum-of-absolute-differences pass on the
//   customSad datapath. Issues one address per ACC cycle, delays the
//   accumulate strobe by MEM_LAT cycles to match memory read latency, then
//   stores the sum and pulses done.
//
// Build option
//   SAD_CTRL_ABORT_EN : adds the `abort` input, which returns any busy
//                       state to IDLE on the next edge and flushes the pipe.
//
// Parameters
//   MEM_LAT    A/B memory read latency in cycles, 0..3 (0 = async read)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   go         in   start request, only honoured in IDLE
//   abort      in   (SAD_CTRL_ABORT_EN only) cancel the current pass
//   i_lt_256   in   datapath status, low when ab_addr == 255
//   i_inc      out  increment ab_addr
//   i_clr      out  clear ab_addr
//   sum_ld     out  accumulate |a-b| into sumReg
//   sum_clr    out  clear sumReg
//   sadreg_ld  out  copy sumReg into sad
//   sadreg_clr out  clear sad
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse, sad valid in that cycle
// ---------------------------------------------------------------------------
module sad_ctrl
    import sad_pkg::*;
#(
    parameter int MEM_LAT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
`ifdef SAD_CTRL_ABORT_EN
    input  logic abort,
`endif
    input  logic i_lt_256,
    output logic i_inc,
    output logic i_clr,
    output logic sum_ld,
    output logic sum_clr,
    output logic sadreg_ld,
    output logic sadreg_clr,
    output logic busy,
    output logic done
);

    localparam logic [1:0] LAT_LAST = sad_lat_last(MEM_LAT);

    sad_state_t state_q;
    logic [1:0] drain_q;
    logic       token_w;
    logic       flush_w;
    logic       pipe_out_w;
    logic       abort_hit_w;

`ifdef SAD_CTRL_ABORT_EN
    // Abort is meaningless in IDLE, so a simultaneous go still starts a pass.
    assign abort_hit_w = abort && (state_q != S_IDLE);
`else
    assign abort_hit_w = 1'b0;
`endif

    // One token per issued address; every ACC cycle issues one.
    assign token_w = (state_q == S_ACC);

    // The pipe must be empty when a pass begins and after a cancelled pass.
    assign flush_w = (state_q == S_CLR) || abort_hit_w;

    sad_lat_pipe #(
        .DEPTH (MEM_LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_w),
        .valid_i (token_w),
        .valid_o (pipe_out_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            drain_q <= 2'd0;
        end else if (abort_hit_w) begin
            state_q <= S_IDLE;
            drain_q <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_q <= S_CLR;
                    end
                end
                S_CLR: begin
                    drain_q <= 2'd0;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    // Address 255 is being issued: this is the last token.
                    if (!i_lt_256) begin
                        state_q <= (MEM_LAT == 0) ? S_STORE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Hold here until the final token leaves the pipe.
                    if (drain_q == LAT_LAST) begin
                        state_q <= S_STORE;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                S_STORE: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes depend only on the state register, the pipe output and the
    // datapath status, never on go.
    assign busy       = (state_q != S_IDLE);
    assign i_clr      = (state_q == S_CLR);
    assign sum_clr    = (state_q == S_CLR);
    assign sadreg_clr = (state_q == S_CLR);
    assign i_inc      = (state_q == S_ACC) && i_lt_256;
    assign sum_ld     = pipe_out_w;
    assign sadreg_ld  = (state_q == S_STORE);
    assign done       = (state_q == S_DONE);

endmodule

// File: doc/sad_ctrl.md
# sad_ctrl

Control FSM that sequences one 256-element sum-of-absolute-differences pass on the `customSad` datapath, sitting directly upstream of it. It accepts a start pulse from the system side and drives the datapath's index, accumulator and result-register control strobes. It consumes the datapath's `i_lt_256` status, compensates for a configurable A/B memory read latency, and reports completion with a one-cycle `done` pulse.

## Interface
- `MEM_LAT`, 0: read latency, in cycles, from `ab_addr` to valid `a_data`/`b_data`. Legal range is 0..3; 0 means asynchronous read.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `go`  in  1  start request, sampled in IDLE.
- `i_lt_256`  in  1  datapath status; low when `ab_addr` == 255.
- `i_inc`  out  1  increment `ab_addr`.
- `i_clr`  out  1  clear `ab_addr` to 0.
- `sum_ld`  out  1  accumulate the current `|a-b|` into `sumReg`.
- `sum_clr`  out  1  clear `sumReg`.
- `sadreg_ld`  out  1  copy `sumReg` into `sad`.
- `sadreg_clr`  out  1  clear `sad`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `sad` is valid in that cycle.

## Operation
- **States:** IDLE, CLR, ACC, DRAIN, STORE, DONE.
- **IDLE:** all strobes low. `go`=1 moves to CLR; `go`=0 stays in IDLE.
- **CLR:** `i_clr`=`sum_clr`=`sadreg_clr`=1. Clears the drain counter and the latency pipe. Next state is ACC.
- **ACC:** one address is issued per cycle. Each ACC cycle pushes a valid token into the latency pipe.
  - If `i_lt_256`=1: `i_inc`=1 and the FSM stays in ACC.
  - If `i_lt_256`=0 (address 255): `i_inc`=0, the last token is issued, and the FSM goes to DRAIN. If MEM_LAT=0, it goes straight to STORE.
- **`sum_ld` source:** with MEM_LAT=0, `sum_ld` equals the token issued this cycle. Otherwise `sum_ld` is the token delayed by exactly MEM_LAT cycles.
- **DRAIN:** no new tokens. The FSM counts MEM_LAT cycles, the pipe emptying as it goes, then moves to STORE.
- **STORE:** `sadreg_ld`=1. Next state is DONE.
- **DONE:** `done`=1 for one cycle. Next state is IDLE. A `go` held high is not seen until the following IDLE cycle.
- **`go` while busy:** ignored, not queued.
- **Strobe decoding:** all strobes are decoded from the state register plus the pipe output. No strobe is a function of `go`.
- **Mutual exclusion:** `i_clr` and `i_inc` are never high together. `sum_clr` and `sum_ld` are never high together.
- **Element count:** exactly 256 `sum_ld` pulses per pass, regardless of MEM_LAT.

## Timing
- **Reset values:** while `rst` is high, state=IDLE, the pipe and drain counter are 0, and every output is 0. Reset takes effect immediately.
- **Reset mid-pass:** the FSM returns to IDLE, the pipe is flushed, and no `sadreg_ld` is issued.
- **Cycle map,** with `go` sampled high in cycle 0:
  - CLR in cycle 1.
  - ACC in cycles 2..257, presenting addresses 0..255.
  - DRAIN in cycles 258..257+MEM_LAT.
  - STORE in cycle 258+MEM_LAT.
  - DONE in cycle 259+MEM_LAT.
- **Latency:** `go` to `done` is 259+MEM_LAT cycles.
- **Back-to-back passes:** with `go` asserted in the cycle after DONE, the minimum pass period is 260+MEM_LAT cycles.
- **`sum_ld` window:** first pulse in cycle 2+MEM_LAT, last in cycle 257+MEM_LAT, contiguous.

## Configuration
- **`SAD_CTRL_ABORT_EN` defined:** adds input port `abort` (1 bit).
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge and flushes the pipe.
  - No `sadreg_ld` or `done` follows an abort.
  - `abort` takes priority over `go` and over every other transition.
  - `abort` in IDLE has no effect.
- **Undefined:** no `abort` port. A pass can only be stopped by `rst`.

## Structure
- **Package `sad_pkg`:**
  - state enum typedef `sad_state_t`.
  - constant `SAD_N`=256.
  - constant `SAD_MAX_LAT`=3.
- **Sub-module `sad_lat_pipe`:**
  - parameterised valid shift register of depth MEM_LAT, with an asynchronous-reset and synchronous-flush input.
  - MEM_LAT=0 makes it a wire.

## Test plan
- **MEM_LAT=0, single pass:** `go` pulse at cycle 0 with a datapath model.
  - 256 contiguous `sum_ld` pulses in cycles 2..257.
  - `sadreg_ld` at 258, `done` at 259.
  - With a[i]=i and b[i]=0, `sad`=32640.
- **MEM_LAT=3:** same stimulus through a 3-deep memory model.
  - `sum_ld` in cycles 5..260.
  - `done` at 262.
  - `sad`=32640.
- **`go` held high continuously:**
  - `go` during busy is ignored.
  - Passes start at cycles 0, 260, 520.
  - Exactly 3 `done` pulses by cycle 780 (MEM_LAT=0).
- **`rst` asserted at cycle 100 of a pass:**
  - All outputs are 0 immediately.
  - No `done` follows.
  - The next `go` gives a full, correct pass.
- **Signed data, |a-b| with mixed signs:** a[i]=-5 and b[i]=3 for all i → `sad`=2048.
- **With `SAD_CTRL_ABORT_EN`:**
  - `abort` at cycle 50 → IDLE at 51, no `sadreg_ld`.
  - `abort` and `go` together in IDLE → the pass starts.
